// File: rtl/split_channel_arbiter.sv
// split_channel_arbiter: two requesters (A, B) share one valid/ready channel.
// Round-robin grant, single-entry output register with source tag,
// and saturating per-requester grant counters.
module split_channel_arbiter #(
  parameter int DW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arb_en,
  input  logic          a_valid,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_src,
  input  logic          out_ready,
  output logic [CW-1:0] grant_cnt_a,
  output logic [CW-1:0] grant_cnt_b,
  output logic          busy
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e        state_q,    state_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_src_q,  out_src_d;
  logic          last_src_q, last_src_d;
  logic [CW-1:0] cnt_a_q,    cnt_a_d;
  logic [CW-1:0] cnt_b_q,    cnt_b_d;

  logic          grant_a_s;
  logic          grant_b_s;
  logic          can_load_s;
  logic          accept_a_s;
  logic          accept_b_s;

  // Increment that sticks at the all-ones value.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == {CW{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CW-1){1'b0}}, 1'b1};
    end
  endfunction

  // Round-robin grant: contested cycles go to the side opposite last_src.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    case ({a_valid, b_valid})
      2'b10: grant_a_s = 1'b1;
      2'b01: grant_b_s = 1'b1;
      2'b11: begin
        if (last_src_q == 1'b1) begin
          grant_a_s = 1'b1;
        end else begin
          grant_b_s = 1'b1;
        end
      end
      default: begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
      end
    endcase
  end

  // Load is allowed when enabled and the register is empty or draining; reset blocks it.
  assign can_load_s = arb_en & ((state_q == EMPTY) | out_ready) & ~rst;
  assign accept_a_s = can_load_s & grant_a_s;
  assign accept_b_s = can_load_s & grant_b_s;

  assign a_ready     = accept_a_s;
  assign b_ready     = accept_b_s;
  assign out_valid   = (state_q == FULL);
  assign busy        = (state_q == FULL);
  assign out_data    = out_data_q;
  assign out_src     = out_src_q;
  assign grant_cnt_a = cnt_a_q;
  assign grant_cnt_b = cnt_b_q;

  // Next-state: accept overrides drain so a same-edge drain+load keeps the register full.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    last_src_d = last_src_q;
    cnt_a_d    = cnt_a_q;
    cnt_b_d    = cnt_b_q;
    if (accept_a_s) begin
      state_d    = FULL;
      out_data_d = a_data;
      out_src_d  = 1'b0;
      last_src_d = 1'b0;
      cnt_a_d    = sat_inc(cnt_a_q);
    end else if (accept_b_s) begin
      state_d    = FULL;
      out_data_d = b_data;
      out_src_d  = 1'b1;
      last_src_d = 1'b1;
      cnt_b_d    = sat_inc(cnt_b_q);
    end else if ((state_q == FULL) && out_ready) begin
      state_d    = EMPTY;
    end else begin
      state_d    = state_q;
    end
  end

  // State register; last_src resets to B so A wins the first contested cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      out_data_q <= {DW{1'b0}};
      out_src_q  <= 1'b0;
      last_src_q <= 1'b1;
      cnt_a_q    <= {CW{1'b0}};
      cnt_b_q    <= {CW{1'b0}};
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_src_q  <= out_src_d;
      last_src_q <= last_src_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
    end
  end

endmodule

// File: tb/tb_split_channel_arbiter.sv
// Testbench for split_channel_arbiter: directed vector table plus
// hand-written sequences for counter saturation and mid-transfer reset.
module tb_split_channel_arbiter;

  logic       clk = 1'b0;
  logic       rst, arb_en, a_valid, b_valid, out_ready;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready, out_valid, out_src, busy;
  logic [7:0] out_data, grant_cnt_a, grant_cnt_b;

  int compared   = 0;
  int mismatched = 0;

  split_channel_arbiter #(.DW(8), .CW(8)) dut (
    .clk(clk), .rst(rst), .arb_en(arb_en),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready),
    .grant_cnt_a(grant_cnt_a), .grant_cnt_b(grant_cnt_b), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic       av;
    logic [7:0] ad;
    logic       bv;
    logic [7:0] bd;
    logic       ordy;
    logic       e_ar;
    logic       e_br;
    logic       e_ov;
    logic [7:0] e_d;
    logic       e_src;
    logic [7:0] e_ca;
    logic [7:0] e_cb;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic en, input logic av, input logic [7:0] ad,
                       input logic bv, input logic [7:0] bd, input logic ordy);
    @(negedge clk);
    rst = r; arb_en = en; a_valid = av; a_data = ad;
    b_valid = bv; b_data = bd; out_ready = ordy;
    #1;
  endtask

  task automatic check_out(input string tag, input logic ov, input logic [7:0] d,
                           input logic src, input logic [7:0] ca, input logic [7:0] cb);
    check({tag, ".out_valid"}, int'(out_valid), int'(ov));
    check({tag, ".busy"}, int'(busy), int'(ov));
    check({tag, ".out_data"}, int'(out_data), int'(d));
    check({tag, ".out_src"}, int'(out_src), int'(src));
    check({tag, ".cnt_a"}, int'(grant_cnt_a), int'(ca));
    check({tag, ".cnt_b"}, int'(grant_cnt_b), int'(cb));
  endtask

  initial begin
    rst = 1'b1; arb_en = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    a_data = 8'h00; b_data = 8'h00; out_ready = 1'b0;

    //             rst   en    av    ad     bv    bd     ordy  ar    br    ov    d      src   ca     cb
    // reset with A requesting: readies forced low
    vecs.push_back('{1'b1, 1'b1, 1'b1, 8'h99, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 8'd0});
    // single A beat
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'd1, 8'd0});
    // reset again so the contested run starts fresh
    vecs.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 8'd0});
    // both valid for 6 cycles: A,B,A,B,A,B
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'hA0, 1'b1, 8'hB0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA0, 1'b0, 8'd1, 8'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'hA1, 1'b1, 8'hB0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB0, 1'b1, 8'd1, 8'd1});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'hA1, 1'b1, 8'hB1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b0, 8'd2, 8'd1});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'hA2, 1'b1, 8'hB1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB1, 1'b1, 8'd2, 8'd2});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'hA2, 1'b1, 8'hB2, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA2, 1'b0, 8'd3, 8'd2});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'hA3, 1'b1, 8'hB2, 1'b1, 1'b0, 1'b1, 1'b1, 8'hB2, 1'b1, 8'd3, 8'd3});
    // load 0x55 from B, then stall 3 cycles with A waiting
    vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55, 1'b1, 8'd3, 8'd4});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h66, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 8'd3, 8'd4});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h66, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 8'd3, 8'd4});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h66, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 8'd3, 8'd4});
    // out_ready rises: drain and load A in the same cycle
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h66, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h66, 1'b0, 8'd4, 8'd4});
    // load 0x22, then arb_en low: drain only, no refill
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 8'd5, 8'd4});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22, 1'b0, 8'd5, 8'd4});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22, 1'b0, 8'd5, 8'd4});
    // re-enable while empty with out_ready low: load still allowed
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 8'd6, 8'd4});
    // full and stalled with both requesting: nothing moves
    vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h44, 1'b1, 8'hB9, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 8'd6, 8'd4});

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("v%0d", i);
      drive(vecs[i].rst, vecs[i].en, vecs[i].av, vecs[i].ad, vecs[i].bv, vecs[i].bd, vecs[i].ordy);
      check({tag, ".a_ready"}, int'(a_ready), int'(vecs[i].e_ar));
      check({tag, ".b_ready"}, int'(b_ready), int'(vecs[i].e_br));
      @(posedge clk);
      #1;
      check_out(tag, vecs[i].e_ov, vecs[i].e_d, vecs[i].e_src, vecs[i].e_ca, vecs[i].e_cb);
    end

    // Saturation: 255 accepts from A, then two more that must hold the count at 255
    drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    @(posedge clk);
    for (int k = 0; k < 255; k++) begin
      drive(1'b0, 1'b1, 1'b1, 8'(k), 1'b0, 8'h00, 1'b1);
      @(posedge clk);
    end
    #1;
    check("sat.pre_cnt_a", int'(grant_cnt_a), 255);
    check("sat.pre_data", int'(out_data), 8'hFE);
    drive(1'b0, 1'b1, 1'b1, 8'hE1, 1'b0, 8'h00, 1'b1);
    check("sat1.a_ready", int'(a_ready), 1);
    @(posedge clk);
    #1;
    check_out("sat1", 1'b1, 8'hE1, 1'b0, 8'd255, 8'd0);
    drive(1'b0, 1'b1, 1'b1, 8'hE2, 1'b0, 8'h00, 1'b1);
    check("sat2.a_ready", int'(a_ready), 1);
    @(posedge clk);
    #1;
    check_out("sat2", 1'b1, 8'hE2, 1'b0, 8'd255, 8'd0);

    // Give B the last grant so the post-reset contested grant really tests the pointer reset
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'hBB, 1'b1);
    check("pre_rst.b_ready", int'(b_ready), 1);
    @(posedge clk);
    #1;
    check_out("pre_rst", 1'b1, 8'hBB, 1'b1, 8'd255, 8'd1);

    // Reset while full with A valid: ready low, beat discarded, counters cleared
    drive(1'b1, 1'b1, 1'b1, 8'h77, 1'b0, 8'h00, 1'b1);
    check("mrst.a_ready", int'(a_ready), 0);
    @(posedge clk);
    #1;
    check_out("mrst", 1'b0, 8'h00, 1'b0, 8'd0, 8'd0);

    // First contested grant after reset goes to A, then B
    drive(1'b0, 1'b1, 1'b1, 8'hC1, 1'b1, 8'hD1, 1'b1);
    check("post1.a_ready", int'(a_ready), 1);
    check("post1.b_ready", int'(b_ready), 0);
    @(posedge clk);
    #1;
    check_out("post1", 1'b1, 8'hC1, 1'b0, 8'd1, 8'd0);
    drive(1'b0, 1'b1, 1'b1, 8'hC2, 1'b1, 8'hD1, 1'b1);
    check("post2.a_ready", int'(a_ready), 0);
    check("post2.b_ready", int'(b_ready), 1);
    @(posedge clk);
    #1;
    check_out("post2", 1'b1, 8'hD1, 1'b1, 8'd1, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/split_channel_arbiter.md
# split_channel_arbiter

Round-robin arbiter sharing one 8-bit valid/ready channel between two requesters, A and B. Each accepted beat is captured into a single-entry output register. That register presents the beat downstream with its source tag. The block sits in front of the `my_if`-style data/valid/ready channel and replaces ad-hoc fork-based concurrent driving of `data`/`ready` with an explicit, fair, one-writer-per-cycle schedule. It also keeps saturating per-requester grant counters for status.

## Interface
Parameters:
- `DW`, 8, data width of requester and output channels.
- `CW`, 8, width of each grant counter.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `arb_en`  input  1  enables acceptance of new beats; low blocks new grants but never blocks draining.
- `a_valid`  input  1  requester A has a beat.
- `a_data`  input  DW  requester A payload.
- `a_ready`  output  1  A's beat is accepted this cycle.
- `b_valid`  input  1  requester B has a beat.
- `b_data`  input  DW  requester B payload.
- `b_ready`  output  1  B's beat is accepted this cycle.
- `out_valid`  output  1  output register holds a beat.
- `out_data`  output  DW  held payload.
- `out_src`  output  1  source of held beat: 0 = A, 1 = B.
- `out_ready`  input  1  downstream consumes the held beat this cycle.
- `grant_cnt_a`  output  CW  saturating count of beats accepted from A.
- `grant_cnt_b`  output  CW  saturating count of beats accepted from B.
- `busy`  output  1  equals `out_valid`.

## Operation
- State is one bit: EMPTY when `out_valid`=0, FULL when `out_valid`=1.
- `can_load` = `arb_en` & (EMPTY | `out_ready`). The register supports full throughput: a beat can be loaded in the same cycle the held beat drains.
- Grant, combinational:
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the requester opposite to `last_src`.
  - Neither valid: no grant.
- `a_ready` = `can_load` & grant A. `b_ready` = `can_load` & grant B. At most one is high in any cycle.
- Both ready signals are low whenever `can_load` is 0, whether or not any request is valid.
- Accept (`x_valid` & `x_ready`) at an edge has these effects:
  - `out_data` and `out_src` load the granted requester's data and ID.
  - `out_valid` becomes 1.
  - `last_src` is updated to the granted ID.
  - That requester's counter increments, holding at 2^CW−1.
- Drain (FULL & `out_ready`) with no accept at the same edge: `out_valid` becomes 0. `out_data` and `out_src` keep their last values.
- Drain and accept at the same edge: the new beat replaces the old one and `out_valid` stays 1.
- FULL & !`out_ready`: output is frozen and both ready signals are 0. Requesters must hold `valid` and `data` stable; this is not checked.
- `arb_en`=0 while FULL: the held beat still drains normally; no refill occurs.
- `last_src` changes only on accept. Pointer movement never depends on a requester valid being seen without an accept.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_src`=0.
  - `last_src`=1, so A wins the first contested cycle.
  - Both counters 0, `busy`=0.
  - `a_ready` and `b_ready` are 0 during reset.
- Latency: a beat accepted at edge N appears on `out_*` immediately after edge N. Request to output is 1 cycle.
- Throughput: 1 beat/cycle when `out_ready` stays high and `arb_en`=1.
- With both requesters continuously valid, grants alternate exactly A, B, A, B…
- Reset asserted mid-transfer discards the held beat and clears counters at that edge. Any concurrent `x_valid`&`x_ready` is ignored because the ready signals are forced to 0.
- Counter saturation: from 2^CW−1, a further accept leaves the value unchanged. The beat is still transferred.

## Test plan
- Reset, then A valid with `a_data`=0x11, `out_ready`=1 → `a_ready`=1 at cycle 0. Next cycle: `out_valid`=1, `out_data`=0x11, `out_src`=0, `grant_cnt_a`=1.
- Both valid (A=0xA0.., B=0xB0..) for 6 cycles, `out_ready`=1 → grant order A,B,A,B,A,B; counters end at 3/3. Output stream is 0xA0,0xB0,0xA1,0xB1,… one cycle behind.
- Load 0x55 from B, then `out_ready`=0 for 3 cycles with A valid → `a_ready`=0 and output held 0x55/src 1. When `out_ready` rises: drain and load A's beat in the same cycle, `out_valid` stays 1.
- FULL with 0x22, `arb_en`=0, `out_ready`=1, A valid → beat drains, `out_valid`=0 next cycle, `a_ready` stays 0 throughout.
- Preload `grant_cnt_a` to 255 via 255 accepts from A, then 2 more accepts → counter stays 255 and both beats still appear on `out_data`.
- Assert `rst` while FULL with A valid → next cycle `out_valid`=0 and counters 0. The first contested grant after reset goes to A.
